// File: rtl/sub_pkg.sv
// -----------------------------------------------------------------------------
// sub_pkg
//   Shared definitions for the shared magnitude-difference arbiter:
//   FSM state encoding, default operand width and a constant clog2 helper
//   used to size requester-index fields.
// -----------------------------------------------------------------------------
package sub_pkg;

    localparam int WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Ceiling log2, usable in parameter expressions; returns 0 for n <= 1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sub_magnitude.sv
// -----------------------------------------------------------------------------
// sub_magnitude
//   Combinational |a-b| using two's-complement addition of the negated
//   smaller operand; the carry out is dropped by truncation to WIDTH.
// Ports:
//   a, b  in  [WIDTH-1:0]  unsigned operands
//   diff  out [WIDTH-1:0]  |a-b|
//   neg   out              1 when a < b
// -----------------------------------------------------------------------------
module sub_magnitude #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             neg
);

    logic [WIDTH-1:0] neg_a;
    logic [WIDTH-1:0] neg_b;

    assign neg_a = ~a + WIDTH'(1);
    assign neg_b = ~b + WIDTH'(1);

    // a == b falls into the second branch and yields b + (-a) = 0.
    assign diff = (a > b) ? (a + neg_b) : (b + neg_a);
    assign neg  = (a < b);

endmodule

// File: rtl/sub_share_arbiter.sv
// -----------------------------------------------------------------------------
// sub_share_arbiter
//   Shares one sub_magnitude unit among N_REQ requesters. A round-robin
//   search picks one valid requester in IDLE, its operands are latched, the
//   difference is computed and registered in CALC, and the result is held
//   in DONE until the consumer accepts it. One operation is in flight at a
//   time, so best-case throughput is one result every three cycles.
// Ports:
//   clk        in                 rising-edge clock
//   rst        in                 asynchronous active-high reset
//   req_valid  in  [N_REQ-1:0]    requester i presents operands
//   req_a      in  [N_REQ*WIDTH]  operand a, slice i = [i*WIDTH +: WIDTH]
//   req_b      in  [N_REQ*WIDTH]  operand b, same slicing
//   req_ready  out [N_REQ-1:0]    one-hot grant (IDLE only)
//   res_valid  out                result registers hold a valid result
//   res_ready  in                 consumer accepts the result
//   res_diff   out [WIDTH-1:0]    |a-b|
//   res_neg    out                1 when a < b
//   res_id     out [IDW-1:0]      requester that issued the operation
// -----------------------------------------------------------------------------
module sub_share_arbiter
    import sub_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = WIDTH_DEF,
    parameter int IDW   = clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [WIDTH-1:0]       res_diff,
    output logic                   res_neg,
    output logic [IDW-1:0]         res_id
);

    state_t           state_reg;
    state_t           state_next;
    logic [IDW-1:0]   rr_ptr_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [IDW-1:0]   id_reg;
    logic [WIDTH-1:0] res_diff_reg;
    logic             res_neg_reg;
    logic [IDW-1:0]   res_id_reg;
    logic             res_valid_reg;

    logic [WIDTH-1:0] a_slice [N_REQ];
    logic [WIDTH-1:0] b_slice [N_REQ];
    logic             grant_found;
    logic [IDW-1:0]   grant_id;
    logic [N_REQ-1:0] grant_vec;
    logic             handshake;
    logic [WIDTH-1:0] mag_diff;
    logic             mag_neg;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_slice
            assign a_slice[gi] = req_a[gi*WIDTH +: WIDTH];
            assign b_slice[gi] = req_b[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Scan from rr_ptr upward with wrap; the first valid requester wins.
    always_comb begin
        int             idx;
        logic [IDW-1:0] idx_l;
        grant_found = 1'b0;
        grant_id    = '0;
        idx         = 0;
        idx_l       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_ptr_reg) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            idx_l = IDW'(idx);
            if (!grant_found && req_valid[idx_l]) begin
                grant_found = 1'b1;
                grant_id    = idx_l;
            end
        end
    end

    assign grant_vec = grant_found ? (N_REQ'(1) << grant_id) : '0;

    // The grant is derived from req_valid, so any grant in IDLE is a handshake.
    always_comb begin
        state_next = state_reg;
        req_ready  = '0;
        handshake  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                req_ready = grant_vec;
                if (grant_found) begin
                    handshake  = 1'b1;
                    state_next = ST_CALC;
                end
            end
            ST_CALC: begin
                state_next = ST_DONE;
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    sub_magnitude #(
        .WIDTH (WIDTH)
    ) u_mag (
        .a    (a_reg),
        .b    (b_reg),
        .diff (mag_diff),
        .neg  (mag_neg)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_reg    <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            id_reg        <= '0;
            res_diff_reg  <= '0;
            res_neg_reg   <= 1'b0;
            res_id_reg    <= '0;
            res_valid_reg <= 1'b0;
        end else begin
            if (handshake) begin
                a_reg  <= a_slice[grant_id];
                b_reg  <= b_slice[grant_id];
                id_reg <= grant_id;
                // The winner drops to lowest priority for the next search.
                rr_ptr_reg <= (grant_id == IDW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
            end
            if (state_reg == ST_CALC) begin
                res_diff_reg  <= mag_diff;
                res_neg_reg   <= mag_neg;
                res_id_reg    <= id_reg;
                res_valid_reg <= 1'b1;
            end
            if (state_reg == ST_DONE && res_ready) begin
                res_valid_reg <= 1'b0;
            end
        end
    end

    assign res_valid = res_valid_reg;
    assign res_diff  = res_diff_reg;
    assign res_neg   = res_neg_reg;
    assign res_id    = res_id_reg;

endmodule

// File: tb/tb_sub_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sub_share_arbiter
//   Self-checking bench for sub_share_arbiter. Inputs are driven on the
//   falling edge and outputs sampled 1 ns later. Expected grants come from a
//   round-robin pointer kept as an integer and a linear scan; expected results
//   come from plain integer subtraction.
// -----------------------------------------------------------------------------
module tb_sub_share_arbiter;

    localparam int N   = 4;
    localparam int W   = 4;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_ready;
    logic           res_valid;
    logic           res_ready;
    logic [W-1:0]   res_diff;
    logic           res_neg;
    logic [IDW-1:0] res_id;

    logic [W-1:0] op_a [N];
    logic [W-1:0] op_b [N];

    int vectors     = 0;
    int miscompares = 0;
    int model_ptr   = 0;

    sub_share_arbiter #(
        .N_REQ (N),
        .WIDTH (W),
        .IDW   (IDW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_diff  (res_diff),
        .res_neg   (res_neg),
        .res_id    (res_id)
    );

    always #5 clk = ~clk;

    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = op_a[i];
            req_b[i*W +: W] = op_b[i];
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            assert ($onehot0(req_ready)) else begin
                miscompares++;
                $display("FAIL onehot: req_ready=%b is not one-hot-or-zero", req_ready);
            end
        end
    end

    // Reference: first valid requester at or after ptr, wrapping; -1 if none.
    function automatic int model_grant(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (ptr + k) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] ref_diff(input int a, input int b);
        return (a >= b) ? W'(a - b) : W'(b - a);
    endfunction

    task automatic randomize_ops();
        for (int i = 0; i < N; i++) begin
            op_a[i] = W'($urandom);
            op_b[i] = W'($urandom);
        end
    endtask

    // One full operation from an IDLE falling edge; result held for `stall`
    // extra cycles with res_ready low. Returns at the next IDLE falling edge.
    task automatic run_op(input logic [N-1:0] valids, input int stall);
        int           g;
        logic [N-1:0] exp_rdy;
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        logic [W-1:0] ed;
        logic         en;
        req_valid = valids;
        res_ready = (stall == 0);
        #1;
        g       = model_grant(valids, model_ptr);
        exp_rdy = (g < 0) ? '0 : (N'(1) << g);
        vectors++;
        if (req_ready !== exp_rdy) begin
            miscompares++;
            $display("FAIL grant: req_ready=%b expected %b (valid=%b ptr=%0d)",
                     req_ready, exp_rdy, valids, model_ptr);
        end
        if (g < 0) begin
            @(posedge clk);
            @(negedge clk);
            return;
        end
        ea = op_a[g];
        eb = op_b[g];
        @(posedge clk);
        @(negedge clk);
        model_ptr = (g + 1) % N;
        randomize_ops();  // operands must already be latched
        vectors++;
        if (req_ready !== '0 || res_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL calc: req_ready=%b res_valid=%b expected 0000/0",
                     req_ready, res_valid);
        end
        @(posedge clk);
        @(negedge clk);
        ed = ref_diff(int'(ea), int'(eb));
        en = (ea < eb);
        vectors++;
        if (res_valid !== 1'b1 || res_diff !== ed || res_neg !== en || res_id !== IDW'(g)) begin
            miscompares++;
            $display("FAIL result: valid=%b diff=%0d neg=%b id=%0d expected 1/%0d/%b/%0d (a=%0d b=%0d)",
                     res_valid, res_diff, res_neg, res_id, ed, en, g, ea, eb);
        end
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            @(negedge clk);
            vectors++;
            if (res_valid !== 1'b1 || res_diff !== ed || res_neg !== en || req_ready !== '0) begin
                miscompares++;
                $display("FAIL stall: valid=%b diff=%0d neg=%b ready=%b expected 1/%0d/%b/0000",
                         res_valid, res_diff, res_neg, req_ready, ed, en);
            end
            if (s == stall - 1) res_ready = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (res_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL release: res_valid=%b expected 0", res_valid);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = '0;
        res_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end
        repeat (2) @(negedge clk);
        vectors++;
        if (req_ready !== '0 || res_valid !== 1'b0 || res_diff !== '0 || res_neg !== 1'b0 || res_id !== '0) begin
            miscompares++;
            $display("FAIL reset_values: ready=%b valid=%b diff=%0d neg=%b id=%0d expected all zero",
                     req_ready, res_valid, res_diff, res_neg, res_id);
        end
        rst       = 1'b0;
        model_ptr = 0;
        // Start an operation, then reset while it is in CALC.
        op_a[2]   = 4'd7;
        op_b[2]   = 4'd1;
        req_valid = 4'b0100;
        #1;
        vectors++;
        if (req_ready !== 4'b0100) begin
            miscompares++;
            $display("FAIL reset_pre_grant: req_ready=%b expected 0100", req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        rst       = 1'b1;
        req_valid = '0;
        #1;
        vectors++;
        if (req_ready !== '0 || res_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_calc: ready=%b valid=%b expected 0000/0", req_ready, res_valid);
        end
        @(posedge clk);
        @(negedge clk);
        rst       = 1'b0;
        model_ptr = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            vectors++;
            if (res_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_no_result: res_valid=%b expected 0 (cycle %0d)", res_valid, c);
            end
        end
        req_valid = 4'b1111;
        #1;
        vectors++;
        if (req_ready !== 4'b0001) begin
            miscompares++;
            $display("FAIL reset_ptr: req_ready=%b expected 0001", req_ready);
        end
        req_valid = '0;
    endtask

    task automatic test_single_op();
        op_a[0] = 4'd9;
        op_b[0] = 4'd3;
        run_op(4'b0001, 0);
    endtask

    task automatic test_neg_equal();
        op_a[1] = 4'd3;  op_b[1] = 4'd9;
        run_op(4'b0010, 0);
        op_a[2] = 4'd5;  op_b[2] = 4'd5;
        run_op(4'b0100, 0);
        op_a[3] = 4'd15; op_b[3] = 4'd0;
        run_op(4'b1000, 0);
    endtask

    task automatic test_round_robin();
        randomize_ops();
        for (int k = 0; k < 5; k++) begin
            run_op(4'b1111, 0);
        end
    endtask

    task automatic test_backpressure();
        randomize_ops();
        run_op(4'b1111, 5);
        run_op(4'b1111, 0);
    endtask

    task automatic test_wrap_skip();
        randomize_ops();
        run_op(4'b0100, 0);  // pointer moves to 3
        run_op(4'b0010, 0);  // skip 3 and 0, wrap to 1; pointer moves to 2
        // Valid dropped before the edge: no handshake, pointer unchanged.
        req_valid = 4'b1000;
        #1;
        vectors++;
        if (req_ready !== 4'b1000) begin
            miscompares++;
            $display("FAIL drop_grant: req_ready=%b expected 1000", req_ready);
        end
        req_valid = '0;
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (res_valid !== 1'b0 || req_ready !== '0) begin
            miscompares++;
            $display("FAIL drop_no_hs: valid=%b ready=%b expected 0/0000", res_valid, req_ready);
        end
        run_op(4'b1111, 0);  // pointer still 2 -> requester 2 wins
    endtask

    task automatic test_random();
        for (int k = 0; k < 40; k++) begin
            randomize_ops();
            run_op(N'($urandom_range(0, 15)), $urandom_range(0, 2));
        end
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_neg_equal();
        test_round_robin();
        test_backpressure();
        test_wrap_skip();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
